// File: rtl/enc_pwm_pkg.sv
// enc_pwm_pkg
// Purpose: shared types and default parameter values for the encoder/PWM mixer.
//   step_t      : per-channel decoded encoder step (none / +1 / -1)
//   DEF_*       : default values for the mixer parameters
package enc_pwm_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2
  } step_t;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DB_DIV = 4;

endpackage

// File: rtl/enc_pwm_mixer_enc_channel.sv
// enc_channel
// Purpose: one encoder channel -- 2-FF synchronisers, tick-sampled 2-bit debounce
//   history, rising-A step decode and the WIDTH-bit level register with
//   wrap/saturate arithmetic and a write override.
// Ports:
//   clk, reset      system clock, async active-high reset
//   enc_a, enc_b    raw encoder inputs (asynchronous)
//   tick            debounce sample strobe from the shared prescaler
//   sat_mode        1: clamp at 0 / max, 0: wrap
//   wr_en, wr_data  level write (already qualified for this channel)
//   level           current level register
module enc_channel
  import enc_pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             tick,
  input  logic             sat_mode,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] level
);

  localparam logic [WIDTH-1:0] LEVEL_MAX = '1;

  logic [1:0] sync_a, sync_b;
  logic [1:0] hist_a, hist_b;
  logic       db_a, db_b;
  logic       db_a_nxt, db_b_nxt;
  step_t      step;

  // The debounced value follows the history only once two consecutive tick
  // samples agree; the step is decoded from the value about to be registered
  // so the level moves in the same cycle the debounced A rises.
  always_comb begin
    db_a_nxt = (hist_a[1] == hist_a[0]) ? hist_a[0] : db_a;
    db_b_nxt = (hist_b[1] == hist_b[0]) ? hist_b[0] : db_b;
    step     = STEP_NONE;
    if (db_a_nxt && !db_a) begin
      step = db_b_nxt ? STEP_DN : STEP_UP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      hist_a <= '0;
      hist_b <= '0;
      db_a   <= 1'b0;
      db_b   <= 1'b0;
      level  <= '0;
    end else begin
      sync_a <= {sync_a[0], enc_a};
      sync_b <= {sync_b[0], enc_b};
      if (tick) begin
        hist_a <= {hist_a[0], sync_a[1]};
        hist_b <= {hist_b[0], sync_b[1]};
      end
      db_a <= db_a_nxt;
      db_b <= db_b_nxt;
      // A write in the same cycle as a step wins; the step is dropped.
      if (wr_en) begin
        level <= wr_data;
      end else begin
        case (step)
          STEP_UP: if (!(sat_mode && level == LEVEL_MAX)) level <= level + 1'b1;
          STEP_DN: if (!(sat_mode && level == '0))        level <= level - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer
// Purpose: NUM_CH rotary-encoder channels each driving a WIDTH-bit level and a
//   PWM output, with bus write/readback of the levels.
// Ports:
//   clk, reset      system clock, async active-high reset
//   enc_a, enc_b    encoder inputs, one bit per channel
//   sat_mode        1: levels saturate, 0: levels wrap
//   wr_en/wr_ch/wr_data  one-cycle level write; out-of-range wr_ch is ignored
//   level_out       packed level registers, ch0 in the LSBs
//   pwm_out         per-channel PWM
//   period_stb      one-cycle pulse marking the first output cycle of a PWM period
module enc_pwm_mixer
  import enc_pwm_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DB_DIV = DEF_DB_DIV,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic                    sat_mode,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [NUM_CH*WIDTH-1:0] level_out,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_stb
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [DB_DIV-1:0] presc;
  logic              tick;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  level  [NUM_CH];
  logic [WIDTH-1:0]  shadow [NUM_CH];

  // Debounce prescaler runs down and ticks at its terminal count of zero.
  assign tick = (presc == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else       presc <= presc - 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    enc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enc_a    (enc_a[i]),
      .enc_b    (enc_b[i]),
      .tick     (tick),
      .sat_mode (sat_mode),
      .wr_en    (wr_en && (wr_ch == CH_W'(i))),
      .wr_data  (wr_data),
      .level    (level[i])
    );
    assign level_out[i*WIDTH +: WIDTH] = level[i];
  end

  // pwm_out and period_stb are both registered from the same cnt value, so the
  // strobe lines up with the first output cycle of each period. Shadows load on
  // the last count so a new level only ever starts on a period boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      period_stb <= 1'b0;
      pwm_out    <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      cnt        <= cnt + 1'b1;
      period_stb <= (cnt == '0);
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= (cnt < shadow[i]);
        if (cnt == CNT_MAX) shadow[i] <= level[i];
      end
    end
  end

endmodule

// File: tb/tb_enc_pwm_mixer.sv
module tb_enc_pwm_mixer;
  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int DB_DIV = 4;
  localparam int MAXV   = (1 << WIDTH) - 1;
  localparam int PER    = 1 << WIDTH;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH-1:0]       enc_a, enc_b;
  logic                    sat_mode, wr_en;
  logic [1:0]              wr_ch;
  logic [WIDTH-1:0]        wr_data;
  logic [NUM_CH*WIDTH-1:0] level_out;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_stb;

  int checks = 0;
  int errors = 0;

  // model state
  int exp_lvl [NUM_CH];
  bit busy    [NUM_CH];
  int pend    [NUM_CH];
  bit pend_ok [NUM_CH];
  int duty    [NUM_CH];
  bit duty_ok [NUM_CH];
  int k  = 0;
  int ph = 0;

  enc_pwm_mixer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DB_DIV(DB_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .sat_mode   (sat_mode),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .level_out  (level_out),
    .pwm_out    (pwm_out),
    .period_stb (period_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int step_model(input int lvl, input bit up, input bit sat);
    if (up) return (lvl == MAXV) ? (sat ? MAXV : 0) : lvl + 1;
    return (lvl == 0) ? (sat ? 0 : MAXV) : lvl - 1;
  endfunction

  function automatic int get_lvl(input int ch);
    return int'(level_out[ch*WIDTH +: WIDTH]);
  endfunction

  // Per-cycle comparison. ph is the PWM output phase seen after the k-th edge
  // since reset release; the duty of a period is the level two cycles before
  // that period's first output cycle.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      k = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        pend[c] = 0; pend_ok[c] = 1'b1; duty[c] = 0; duty_ok[c] = 1'b1;
      end
      check("rst_pwm", pwm_out, 0);
      check("rst_stb", period_stb, 0);
      check("rst_lvl", level_out, 0);
    end else begin
      k++;
      ph = (k - 1) % PER;
      if (ph == 0) begin
        for (int c = 0; c < NUM_CH; c++) begin
          duty[c] = pend[c]; duty_ok[c] = pend_ok[c];
        end
      end
      check("stb", period_stb, (ph == 0));
      for (int c = 0; c < NUM_CH; c++) begin
        if (duty_ok[c]) check($sformatf("pwm%0d", c), pwm_out[c], (ph < duty[c]));
        if (!busy[c])   check($sformatf("lvl%0d", c), level_out[c*WIDTH +: WIDTH], exp_lvl[c]);
      end
      if (ph == PER - 2) begin
        for (int c = 0; c < NUM_CH; c++) begin
          pend[c] = exp_lvl[c]; pend_ok[c] = !busy[c];
        end
      end
    end
  end

  task automatic detent(input int ch, input bit cw);
    busy[ch]    = 1'b1;
    exp_lvl[ch] = step_model(exp_lvl[ch], cw, sat_mode);
    @(negedge clk); enc_b[ch] = !cw;
    repeat (40) @(negedge clk); enc_a[ch] = 1'b1;
    repeat (60) @(negedge clk); enc_a[ch] = 1'b0;
    repeat (60) @(negedge clk); enc_b[ch] = 1'b0;
    repeat (60) @(negedge clk);
    busy[ch] = 1'b0;
  endtask

  task automatic write_lvl(input int ch, input int val);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = WIDTH'(val);
    if (ch < NUM_CH) exp_lvl[ch] = val;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!period_stb && n < 600);
    check(name, period_stb, 1);
  endtask

  int hi;
  bit found;

  initial begin
    enc_a = '0; enc_b = '0; sat_mode = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin exp_lvl[c] = 0; busy[c] = 1'b0; end

    // 1: channels rotating during reset
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      enc_a = {NUM_CH{(i % 4 == 1) || (i % 4 == 2)}};
      enc_b = {NUM_CH{(i % 4 >= 2)}};
    end
    @(negedge clk); enc_a = '0; enc_b = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t1_first_stb", period_stb, 1);
    check("t1_levels", level_out, 0);

    // 2: three CW detents on ch1
    for (int i = 0; i < 3; i++) detent(1, 1'b1);
    check("t2_ch1", get_lvl(1), 3);
    check("t2_ch0", get_lvl(0), 0);
    check("t2_ch2", get_lvl(2), 0);

    // 3: boundaries on ch0
    detent(0, 1'b0);
    check("t3_wrap_dn", get_lvl(0), 255);
    write_lvl(0, 0);
    sat_mode = 1'b1;
    detent(0, 1'b0);
    check("t3_sat_dn", get_lvl(0), 0);
    write_lvl(0, 255);
    detent(0, 1'b1);
    check("t3_sat_up", get_lvl(0), 255);
    sat_mode = 1'b0;
    detent(0, 1'b1);
    check("t3_wrap_up", get_lvl(0), 0);

    // 4: write ch2=64 mid-period
    wait_stb("t4_stb_a");
    repeat (100) @(negedge clk);
    write_lvl(2, 64);
    check("t4_readback", get_lvl(2), 64);
    hi = 0; found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (period_stb) found = 1'b1;
      else hi += int'(pwm_out[2]);
    end
    check("t4_stb_b", found, 1);
    check("t4_before_wrap", hi, 0);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      hi += int'(pwm_out[2]);
      @(negedge clk);
    end
    check("t4_duty", hi, 64);

    // 5: write beats a CW step on ch0, then out-of-range write
    @(negedge clk);
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 8'd10; exp_lvl[0] = 10; enc_b[0] = 1'b0;
    repeat (5) @(negedge clk); enc_a[0] = 1'b1;
    repeat (60) @(negedge clk); wr_en = 1'b0;
    repeat (40) @(negedge clk); enc_a[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("t5_write_wins", get_lvl(0), 10);
    write_lvl(3, 99);
    @(negedge clk);
    check("t5_bad_ch0", get_lvl(0), 10);
    check("t5_bad_ch1", get_lvl(1), 3);
    check("t5_bad_ch2", get_lvl(2), 64);

    // 6: single-cycle A glitches at varying prescaler phase
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); enc_a[1] = 1'b1;
      @(negedge clk); enc_a[1] = 1'b0;
      repeat (37) @(negedge clk);
    end
    check("t6_glitch", get_lvl(1), 3);

    // 6: reset mid-period with level 200
    write_lvl(1, 200);
    wait_stb("t6_stb_a");
    wait_stb("t6_stb_b");
    repeat (50) @(negedge clk);
    check("t6_pwm_high", pwm_out[1], 1);
    #3;
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) exp_lvl[c] = 0;
    #1;
    check("t6_async_pwm", pwm_out, 0);
    check("t6_async_lvl", level_out, 0);
    check("t6_async_stb", period_stb, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_restart_stb", period_stb, 1);
    check("t6_restart_pwm", pwm_out, 0);

    repeat (300) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
